if_stage: RTL

Instruction-fetch stage between the program counter register and the decode stage. It takes the current PC, issues word requests on the instruction-memory request/grant/response port, and tracks in-flight requests in a small in-order buffer. It delivers `{pc, inst}` pairs to decode through a registered IF/ID boundary. It asserts a stall request whenever it cannot take the current PC, and drops wrong-path responses after a jump flush.

---
 rtl/if_stage.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction-fetch stage between the PC register and decode.
//
// Issues word fetches for the current PC on a req/gnt/rvalid instruction
// memory port, tracks granted fetches in an in-order ring of DEPTH entries
// and hands {pc, inst} pairs to decode through a registered IF/ID boundary.
// Responses belonging to requests issued before a jump flush are counted in
// kill_cnt and dropped when they return.
//
// Optional feature macro: IF_MISALIGN_CHECK_EN
//   defined   : adds id_misalign_o, registered with IF/ID as pc[1:0] != 0
//   undefined : the port and its logic are absent
//
// Ports
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   pc_i             current PC (also the request address)
//   ce_i             PC register enable; no fetch while low
//   stall_i[5:0]     stall vector: bit0 holds the PC, bit1 holds IF/ID
//   flush_jump_i     redirect: kills the ring and the IF/ID contents
//   stallreq_o       ask the controller to hold the PC (combinational)
//   imem_req_o       fetch request (combinational)
//   imem_addr_o      fetch address (= pc_i)
//   imem_gnt_i       request accepted this cycle
//   imem_rvalid_i    in-order response valid, >= 1 cycle after grant
//   imem_rdata_i     response instruction word
//   id_pc_o          IF/ID PC
//   id_inst_o        IF/ID instruction (NOP_INST on bubbles)
//   id_valid_o       IF/ID holds a real instruction
//   id_misalign_o    IF/ID PC not word aligned (IF_MISALIGN_CHECK_EN only)
// -----------------------------------------------------------------------------
module if_stage #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic                  ce_i,
    input  logic [5:0]            stall_i,
    input  logic                  flush_jump_i,
    output logic                  stallreq_o,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [31:0]           imem_rdata_i,
    output logic [ADDR_WIDTH-1:0] id_pc_o,
    output logic [31:0]           id_inst_o,
    output logic                  id_valid_o
`ifdef IF_MISALIGN_CHECK_EN
    ,
    output logic                  id_misalign_o
`endif
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned KILL_W = 8;
    localparam int unsigned KSUM_W = KILL_W + 1;

    logic [ADDR_WIDTH-1:0] ring_pc     [DEPTH];
    logic [31:0]           ring_inst   [DEPTH];
    logic [DEPTH-1:0]      ring_filled;

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  fill_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  unfilled;
    logic [KILL_W-1:0] kill_cnt;

    logic              alloc;
    logic              fill;
    logic              pop;
    logic [KSUM_W-1:0] kill_sum;
    logic [KILL_W-1:0] kill_load;

    // Only the PC and IF/ID hold bits matter to this stage.
    logic unused_stall;
    assign unused_stall = ^stall_i[5:2];

    assign imem_req_o  = ce_i & ~flush_jump_i & ~stall_i[0] & (count < CNT_W'(DEPTH));
    assign imem_addr_o = pc_i;
    assign alloc       = imem_req_o & imem_gnt_i;
    assign stallreq_o  = ce_i & ~flush_jump_i & ~alloc;

    // A response fills the ring only when no killed response is still owed.
    assign fill = imem_rvalid_i & (kill_cnt == '0);
    // The head is popped off its registered filled bit, so a response never
    // reaches IF/ID in the cycle it arrives.
    assign pop  = ~flush_jump_i & ~stall_i[1] & ring_filled[head];

    // On flush every unfilled entry becomes a response to drop; a response
    // arriving in the flush cycle itself is already accounted for.
    always_comb begin
        kill_sum = {1'b0, kill_cnt} + KSUM_W'(unfilled);
        if (imem_rvalid_i && (kill_sum != '0)) begin
            kill_sum = kill_sum - KSUM_W'(1);
        end
        kill_load = kill_sum[KILL_W] ? '1 : kill_sum[KILL_W-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head        <= '0;
            tail        <= '0;
            fill_ptr    <= '0;
            count       <= '0;
            unfilled    <= '0;
            kill_cnt    <= '0;
            ring_filled <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ring_pc[i]   <= '0;
                ring_inst[i] <= '0;
            end
        end else if (flush_jump_i) begin
            head        <= '0;
            tail        <= '0;
            fill_ptr    <= '0;
            count       <= '0;
            unfilled    <= '0;
            ring_filled <= '0;
            kill_cnt    <= kill_load;
        end else begin
            // Allocate, fill and pop never touch the same slot: alloc and pop
            // coincide only when the ring is full or empty, and the fill slot
            // is always allocated and unfilled.
            if (alloc) begin
                ring_pc[tail]     <= pc_i;
                ring_filled[tail] <= 1'b0;
                tail              <= tail + PTR_W'(1);
            end
            if (imem_rvalid_i) begin
                if (kill_cnt != '0) begin
                    kill_cnt <= kill_cnt - KILL_W'(1);
                end else begin
                    ring_inst[fill_ptr]   <= imem_rdata_i;
                    ring_filled[fill_ptr] <= 1'b1;
                    fill_ptr              <= fill_ptr + PTR_W'(1);
                end
            end
            if (pop) begin
                ring_filled[head] <= 1'b0;
                head              <= head + PTR_W'(1);
            end
            count    <= count + CNT_W'(alloc) - CNT_W'(pop);
            unfilled <= unfilled + CNT_W'(alloc) - CNT_W'(fill);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_valid_o    <= 1'b0;
            id_pc_o       <= '0;
            id_inst_o     <= NOP_INST;
`ifdef IF_MISALIGN_CHECK_EN
            id_misalign_o <= 1'b0;
`endif
        end else if (flush_jump_i) begin
            id_valid_o <= 1'b0;
            id_inst_o  <= NOP_INST;
        end else if (stall_i[1]) begin
            id_valid_o <= id_valid_o;
        end else if (ring_filled[head]) begin
            id_valid_o    <= 1'b1;
            id_pc_o       <= ring_pc[head];
            id_inst_o     <= ring_inst[head];
`ifdef IF_MISALIGN_CHECK_EN
            id_misalign_o <= (ring_pc[head][1:0] != 2'b00);
`endif
        end else begin
            id_valid_o <= 1'b0;
            id_inst_o  <= NOP_INST;
        end
    end

endmodule
